// File: rtl/spi_update_sched_if.sv
// spi_update_sched_if
//   Request/accept handshake between the host-side requesters and the SPI
//   update scheduler. There is one valid/data/ready group per rbzero peripheral.
//   master : requester side; drives *_valid and *_data, receives *_ready
//   slave  : scheduler side; receives *_valid and *_data, drives *_ready
//   vec_valid/vec_data/vec_ready : vector update request, VEC_BITS payload
//   reg_valid/reg_data/reg_ready : register update request, REG_BITS payload
interface spi_update_sched_if #(
  parameter int VEC_BITS = 74,
  parameter int REG_BITS = 28
) ();
  logic                vec_valid;
  logic [VEC_BITS-1:0] vec_data;
  logic                vec_ready;
  logic                reg_valid;
  logic [REG_BITS-1:0] reg_data;
  logic                reg_ready;

  modport master (
    output vec_valid, vec_data, reg_valid, reg_data,
    input  vec_ready, reg_ready
  );

  modport slave (
    input  vec_valid, vec_data, reg_valid, reg_data,
    output vec_ready, reg_ready
  );
endinterface

// File: rtl/spi_update_sched.sv
// spi_update_sched
//   Serialises host updates into rbzero's vector and register SPI peripherals.
//   Two requesters are arbitrated round-robin. Each accepted payload is shifted
//   out as one mode-0, MSB-first SPI frame on that peripheral's csb/sclk/mosi.
//   A guard time of 2*SCLK_DIV cycles follows every frame.
// Ports
//   clk, reset        : system clock; synchronous active-high reset
//   vblank            : rbzero o_vblank; only used when VBLANK_GATE_EN is defined
//   bus (slave)       : vec_/reg_ valid, data and ready handshake
//   vec_csb/sclk/mosi : to rbzero i_vec_csb/i_vec_sclk/i_vec_mosi
//   reg_csb/sclk/mosi : to rbzero i_reg_csb/i_reg_sclk/i_reg_mosi
//   busy              : scheduler not idle
//   done              : 1-cycle pulse when a frame's guard time ends
// Build option
//   VBLANK_GATE_EN : when defined, grants are issued only while vblank=1.
//                    A frame that has started still runs to completion.
module spi_update_sched #(
  parameter int VEC_BITS = 74,
  parameter int REG_BITS = 28,
  parameter int SCLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  spi_update_sched_if.slave bus,
  output logic              vec_csb,
  output logic              vec_sclk,
  output logic              vec_mosi,
  output logic              reg_csb,
  output logic              reg_sclk,
  output logic              reg_mosi,
  output logic              busy,
  output logic              done
);
  localparam int MAXB = (VEC_BITS > REG_BITS) ? VEC_BITS : REG_BITS;
  localparam int BCW  = $clog2(MAXB + 1);
  localparam int DCW  = $clog2(2 * SCLK_DIV + 1);
  localparam logic [DCW-1:0] HALF_LAST  = DCW'(SCLK_DIV - 1);
  localparam logic [DCW-1:0] GUARD_LAST = DCW'(2 * SCLK_DIV - 1);

  // GRANT is the ready-strobe cycle between the grant decision and SETUP.
  typedef enum logic [2:0] {IDLE, GRANT, SETUP, SHIFT_LO, SHIFT_HI, GUARD} state_t;

  state_t          state;
  logic [MAXB-1:0] sr;
  logic [BCW-1:0]  bits;
  logic [DCW-1:0]  cnt;
  logic            last_grant;  // 1 = reg peripheral was granted last
  logic            sel;         // 1 = reg peripheral owns the current frame

  logic gate;
`ifdef VBLANK_GATE_EN
  assign gate = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate = 1'b1;
`endif

  logic want_vec, want_reg, pick_reg, start;
  always_comb begin
    want_vec = bus.vec_valid & gate;
    want_reg = bus.reg_valid & gate;
    // When both are pending, the peripheral that was not served last wins.
    pick_reg = want_reg & (~want_vec | ~last_grant);
    // A new grant can coincide with the guard-exit cycle, so back-to-back
    // frames do not lose an extra idle cycle.
    start    = (want_vec | want_reg) &
               ((state == IDLE) || (state == GUARD && cnt == GUARD_LAST));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sr            <= '0;
      bits          <= '0;
      cnt           <= '0;
      last_grant    <= 1'b1;
      sel           <= 1'b0;
      vec_csb       <= 1'b1;
      vec_sclk      <= 1'b0;
      vec_mosi      <= 1'b0;
      reg_csb       <= 1'b1;
      reg_sclk      <= 1'b0;
      reg_mosi      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.vec_ready <= 1'b0;
      bus.reg_ready <= 1'b0;
    end else begin
      bus.vec_ready <= 1'b0;
      bus.reg_ready <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: ;
        GRANT: begin
          cnt   <= '0;
          state <= SETUP;
          if (sel) begin
            reg_csb  <= 1'b0;
            reg_mosi <= sr[MAXB-1];
          end else begin
            vec_csb  <= 1'b0;
            vec_mosi <= sr[MAXB-1];
          end
        end
        SETUP, SHIFT_LO: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= SHIFT_HI;
            if (sel) reg_sclk <= 1'b1;
            else     vec_sclk <= 1'b1;
          end else begin
            cnt <= cnt + DCW'(1);
          end
        end
        SHIFT_HI: begin
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            bits     <= bits - BCW'(1);
            vec_sclk <= 1'b0;
            reg_sclk <= 1'b0;
            if (bits == BCW'(1)) begin
              // Last bit done: release csb together with the falling edge.
              vec_csb  <= 1'b1;
              vec_mosi <= 1'b0;
              reg_csb  <= 1'b1;
              reg_mosi <= 1'b0;
              state    <= GUARD;
            end else begin
              sr    <= sr << 1;
              state <= SHIFT_LO;
              if (sel) reg_mosi <= sr[MAXB-2];
              else     vec_mosi <= sr[MAXB-2];
            end
          end else begin
            cnt <= cnt + DCW'(1);
          end
        end
        GUARD: begin
          if (cnt == GUARD_LAST) begin
            cnt   <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + DCW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (start) begin
        state      <= GRANT;
        busy       <= 1'b1;
        sel        <= pick_reg;
        last_grant <= pick_reg;
        if (pick_reg) begin
          bus.reg_ready <= 1'b1;
          bits          <= BCW'(REG_BITS);
          sr            <= MAXB'(bus.reg_data) << (MAXB - REG_BITS);
        end else begin
          bus.vec_ready <= 1'b1;
          bits          <= BCW'(VEC_BITS);
          sr            <= MAXB'(bus.vec_data) << (MAXB - VEC_BITS);
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_update_sched.sv
module tb_spi_update_sched;
  localparam int VB = 74;
  localparam int RB = 28;
  localparam int D  = 2;

  logic clk = 1'b0;
  logic reset, vblank;
  logic vec_csb, vec_sclk, vec_mosi, reg_csb, reg_sclk, reg_mosi, busy, done;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   done_at = -1;

  typedef struct {
    bit            p;     // 0 = vec, 1 = reg
    logic [VB-1:0] data;
    int            n;
  } exp_t;
  exp_t sbq[$];

  spi_update_sched_if #(.VEC_BITS(VB), .REG_BITS(RB)) bus_if ();

  spi_update_sched #(.VEC_BITS(VB), .REG_BITS(RB), .SCLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .bus(bus_if.slave),
    .vec_csb(vec_csb), .vec_sclk(vec_sclk), .vec_mosi(vec_mosi),
    .reg_csb(reg_csb), .reg_sclk(reg_sclk), .reg_mosi(reg_mosi),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {vec_csb, vec_sclk, vec_mosi, reg_csb, reg_sclk, reg_mosi,
            bus_if.vec_ready, bus_if.reg_ready, busy, done};
  endfunction

  task automatic push(input bit p, input logic [VB-1:0] d, input int n);
    exp_t e;
    e.p = p; e.data = d; e.n = n;
    sbq.push_back(e);
  endtask

  task automatic wait_ready(input bit p, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((p ? bus_if.reg_ready : bus_if.vec_ready) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk(p ? "reg_ready_timeout" : "vec_ready_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Frame monitor: timing follows the protocol formulas relative to the
  // ready strobe; payloads come from the scoreboard queue.
  task automatic monitor();
    logic c[2], s[2], m[2], r[2];
    logic pc[2] = '{1'b1, 1'b1};
    logic ps[2] = '{1'b0, 1'b0};
    logic pm[2] = '{1'b0, 1'b0};
    int   tg[2] = '{-1000, -1000};
    int   nb[2] = '{0, 0};
    int   cn[2] = '{0, 0};
    bit   act[2] = '{1'b0, 1'b0};
    logic [VB-1:0] fr[2];
    logic [VB-1:0] cd[2];
    exp_t e;
    forever begin
      @(negedge clk);
      c = '{vec_csb, reg_csb};
      s = '{vec_sclk, reg_sclk};
      m = '{vec_mosi, reg_mosi};
      r = '{bus_if.vec_ready, bus_if.reg_ready};
      if (reset === 1'b1) begin
        act = '{1'b0, 1'b0};
        tg  = '{-1000, -1000};
        done_at = -1;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (r[p] === 1'b1) begin
            chk("sb_nonempty", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
              e = sbq.pop_front();
              chk("grant_periph", p, e.p);
              cd[p] = e.data;
              cn[p] = e.n;
            end
            tg[p]  = cyc;
            act[p] = 1'b1;
          end
          if (c[p] === 1'b0 && pc[p] === 1'b1) begin
            chk("csb_fall_time", cyc, tg[p] + 1);
            nb[p] = 0;
            fr[p] = '0;
          end
          if (s[p] === 1'b1 && ps[p] === 1'b0) begin
            chk("sclk_in_frame", c[p], 0);
            chk("sclk_rise_time", cyc, tg[p] + 1 + D * (2 * nb[p] + 1));
            fr[p] = {fr[p][VB-2:0], m[p]};
            nb[p]++;
          end
          if (s[p] === 1'b1 && ps[p] === 1'b1) chk("mosi_stable_hi", m[p], pm[p]);
          if (c[p] === 1'b1) chk("idle_pins", {s[p], m[p]}, 2'b00);
          if (c[p] === 1'b1 && pc[p] === 1'b0 && act[p]) begin
            chk("frame_bits", nb[p], cn[p]);
            chk("frame_data", fr[p], cd[p]);
            chk("csb_rise_time", cyc, tg[p] + 1 + 2 * D * cn[p]);
            done_at = cyc + 2 * D;
            act[p]  = 1'b0;
            tg[p]   = -1000;
          end
        end
        if (c[0] === 1'b0 || c[1] === 1'b0) chk("csb_overlap", c[0] | c[1], 1);
        if (done === 1'b1 || cyc == done_at) begin
          chk("done_time", done, cyc == done_at);
          if (cyc == done_at) done_at = -1;
        end
      end
      pc = c; ps = s; pm = m;
    end
  endtask

  initial begin
    logic [VB-1:0] v1, v2, v3, v4, v5;
    logic [RB-1:0] r1, r2, r3, r6, r7, r8;
    int rises, ndone;
    v1 = 74'h200_1234_5678_9ABC_DEF0;
    v2 = 74'h3FF_0000_FFFF_A5A5_0F0F;
    v3 = 74'h155_AAAA_5555_C3C3_0001;
    v4 = 74'h2AA_DEAD_BEEF_0123_4567;
    v5 = 74'h0C3_8001_7FFE_1248_8421;
    r1 = 28'hA00C3F1; r2 = 28'h5F0F0F0; r3 = 28'h8000001;
    r6 = 28'h3C0FFEE; r7 = 28'hF123456; r8 = 28'h0ABCDEF;

    reset = 1'b1;
`ifdef VBLANK_GATE_EN
    vblank = 1'b1;
`else
    vblank = 1'b0;
`endif
    bus_if.vec_valid = 1'b0; bus_if.vec_data = '0;
    bus_if.reg_valid = 1'b0; bus_if.reg_data = '0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", outs(), 10'b1001000000);

    // Single vector frame
    push(1'b0, v1, VB);
    bus_if.vec_data = v1; bus_if.vec_valid = 1'b1;
    wait_ready(1'b0, 20);
    @(posedge clk); #1 bus_if.vec_valid = 1'b0; bus_if.vec_data = '1;
    wait_done(400);
    @(negedge clk);
    chk("idle_after_vec", {busy, vec_csb}, 2'b01);

    // Single register frame
    push(1'b1, 74'(r1), RB);
    bus_if.reg_data = r1; bus_if.reg_valid = 1'b1;
    wait_ready(1'b1, 20);
    @(posedge clk); #1 bus_if.reg_valid = 1'b0; bus_if.reg_data = '0;
    wait_done(200);

    // Contention from reset: vec, reg, vec, reg
    do_reset();
    push(1'b0, v2, VB); push(1'b1, 74'(r2), RB);
    push(1'b0, v3, VB); push(1'b1, 74'(r3), RB);
    bus_if.vec_data = v2; bus_if.reg_data = r2;
    bus_if.vec_valid = 1'b1; bus_if.reg_valid = 1'b1;
    wait_ready(1'b0, 20);
    @(posedge clk); #1 bus_if.vec_data = v3;
    wait_ready(1'b1, 400);
    @(posedge clk); #1 bus_if.reg_data = r3;
    wait_ready(1'b0, 400);
    @(posedge clk); #1 bus_if.vec_valid = 1'b0;
    wait_ready(1'b1, 400);
    @(posedge clk); #1 bus_if.reg_valid = 1'b0;
    wait_done(200);

    // Reset in the middle of a vector frame
    push(1'b0, v4, VB);
    bus_if.vec_data = v4; bus_if.vec_valid = 1'b1;
    wait_ready(1'b0, 20);
    @(posedge clk); #1 bus_if.vec_valid = 1'b0;
    rises = 0;
    for (int i = 0; i < 200 && rises < 10; i++) begin
      @(negedge clk);
      if (vec_sclk === 1'b1 && vec_csb === 1'b0) begin
        rises++;
        @(negedge clk);
      end
    end
    chk("bits_before_reset", rises, 10);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", outs(), 10'b1001000000);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("no_done_after_reset", ndone, 0);
    push(1'b0, v5, VB);
    bus_if.vec_data = v5; bus_if.vec_valid = 1'b1;
    wait_ready(1'b0, 20);
    @(posedge clk); #1 bus_if.vec_valid = 1'b0;
    wait_done(400);

`ifdef VBLANK_GATE_EN
    // Requests wait for vblank; a started frame survives vblank falling
    vblank = 1'b0;
    push(1'b1, 74'(r6), RB);
    bus_if.reg_data = r6; bus_if.reg_valid = 1'b1;
    ndone = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_if.reg_ready === 1'b1) ndone++;
    end
    chk("gate_holds_ready", ndone, 0);
    vblank = 1'b1;
    wait_ready(1'b1, 5);
    @(posedge clk); #1 bus_if.reg_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 vblank = 1'b0;
    wait_done(200);
    vblank = 1'b1;
`endif

    // Back-to-back register frames: next ready coincides with done
    push(1'b1, 74'(r7), RB); push(1'b1, 74'(r8), RB);
    bus_if.reg_data = r7; bus_if.reg_valid = 1'b1;
    wait_ready(1'b1, 20);
    @(posedge clk); #1 bus_if.reg_data = r8;
    wait_done(200);
    chk("b2b_ready_with_done", bus_if.reg_ready, 1);
    @(posedge clk); #1 bus_if.reg_valid = 1'b0;
    wait_done(200);
    repeat (5) @(negedge clk);
    chk("final_idle", outs(), 10'b1001000000);
    chk("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
